// File: rtl/car_nav.sv
// car_nav: obstacle-avoidance controller.
//   Each raw "path clear" bit is debounced per channel. A four-state FSM
//   (STOP, FWD, TURN, BACK) turns the filtered bits into a one-hot direction
//   command or a timed reverse.
// Ports:
//   clk     - rising-edge clock
//   rst_n   - asynchronous active-low reset
//   en      - drive enable; 0 forces STOP
//   clear   - N_DIR raw sensors, 1 = path clear (bit 0 = front)
//   go      - one-hot direction command, all-zero = no movement
//   go_back - reverse command
//   state   - STOP=00, FWD=01, TURN=10, BACK=11

// Per-channel debouncer. The filtered bit follows the raw bit only after
// DB_CYCLES consecutive mismatching edges.
module car_nav_db #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic filt
);
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            filt <= 1'b0;
        end else if (raw == filt) begin
            cnt <= '0;
        end else if (cnt == CW'(DB_CYCLES - 1)) begin
            filt <= raw;
            cnt  <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

module car_nav #(
    parameter int N_DIR       = 3,
    parameter int DB_CYCLES   = 4,
    parameter int TURN_CYCLES = 8,
    parameter int BACK_CYCLES = 16,
    parameter int STUCK_LIMIT = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_DIR-1:0] clear,
    output logic [N_DIR-1:0] go,
    output logic             go_back,
    output logic [1:0]       state
);
    localparam int KW  = $clog2(N_DIR);
    localparam int SCW = $clog2(STUCK_LIMIT + 1);
    localparam int TCW = $clog2(TURN_CYCLES + 1);
    localparam int BCW = $clog2(BACK_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_STOP = 2'b00,
        ST_FWD  = 2'b01,
        ST_TURN = 2'b10,
        ST_BACK = 2'b11
    } st_e;

    st_e            st, st_nxt;
    logic [N_DIR-1:0] filt;
    logic [KW-1:0]  k, k_nxt, sel;
    logic           side;
    logic [SCW-1:0] stop_cnt;
    logic [TCW-1:0] turn_cnt;
    logic [BCW-1:0] back_cnt;

    car_nav_db #(.DB_CYCLES(DB_CYCLES)) u_db [N_DIR-1:0] (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (clear),
        .filt (filt)
    );

    // Lowest alternate index with a clear path wins (descending scan, last hit kept).
    always_comb begin
        side = 1'b0;
        sel  = '0;
        for (int i = N_DIR - 1; i >= 1; i--) begin
            if (filt[i]) begin
                side = 1'b1;
                sel  = KW'(i);
            end
        end
    end

    always_comb begin
        st_nxt = st;
        k_nxt  = k;
        case (st)
            ST_STOP: begin
                if (!en)                                   st_nxt = ST_STOP;
                else if (filt[0])                          st_nxt = ST_FWD;
                else if (side) begin
                    st_nxt = ST_TURN;
                    k_nxt  = sel;
                end
                else if (stop_cnt == SCW'(STUCK_LIMIT - 1)) st_nxt = ST_BACK;
            end
            ST_FWD: begin
                if (!en)             st_nxt = ST_STOP;
                else if (!filt[0]) begin
                    if (side) begin
                        st_nxt = ST_TURN;
                        k_nxt  = sel;
                    end else begin
                        st_nxt = ST_STOP;
                    end
                end
            end
            ST_TURN: begin
                // Sensor drop outranks dwell expiry; both land in STOP anyway.
                if (!en || !filt[k])                       st_nxt = ST_STOP;
                else if (turn_cnt == TCW'(TURN_CYCLES - 1)) st_nxt = ST_STOP;
            end
            ST_BACK: begin
                if (!en)                                   st_nxt = ST_STOP;
                else if (back_cnt == BCW'(BACK_CYCLES - 1)) st_nxt = ST_STOP;
            end
            default: st_nxt = ST_STOP;
        endcase
    end

    // Each timer counts only while its state persists and clears on any exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= ST_STOP;
            k        <= '0;
            stop_cnt <= '0;
            turn_cnt <= '0;
            back_cnt <= '0;
        end else begin
            st <= st_nxt;
            k  <= k_nxt;

            if (st == ST_STOP && st_nxt == ST_STOP && en) begin
                if (stop_cnt != SCW'(STUCK_LIMIT)) stop_cnt <= stop_cnt + SCW'(1);
            end else begin
                stop_cnt <= '0;
            end

            if (st == ST_TURN && st_nxt == ST_TURN) begin
                if (turn_cnt != TCW'(TURN_CYCLES)) turn_cnt <= turn_cnt + TCW'(1);
            end else begin
                turn_cnt <= '0;
            end

            if (st == ST_BACK && st_nxt == ST_BACK) begin
                if (back_cnt != BCW'(BACK_CYCLES)) back_cnt <= back_cnt + BCW'(1);
            end else begin
                back_cnt <= '0;
            end
        end
    end

    // Outputs come from registered state and k only.
    always_comb begin
        go      = '0;
        go_back = 1'b0;
        case (st)
            ST_FWD:  go      = N_DIR'(1);
            ST_TURN: go      = N_DIR'(1) << k;
            ST_BACK: go_back = 1'b1;
            default: ;
        endcase
    end

    assign state = st;
endmodule

// File: tb/tb_car_nav.sv
module tb_car_nav;
    localparam int DB = 4, TURN = 8, BACK = 16, STUCK = 32;
    localparam int M_STOP = 0, M_FWD = 1, M_TURN = 2, M_BACK = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [2:0] clear = '0;
    logic [2:0] go;
    logic       go_back;
    logic [1:0] state;

    logic       en5 = 1'b0;
    logic [4:0] clear5 = '0;
    logic [4:0] go5;
    logic       go_back5;
    logic [1:0] state5;

    int n_run = 0;
    int n_fail = 0;

    car_nav u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear),
        .go(go), .go_back(go_back), .state(state)
    );

    car_nav #(.N_DIR(5), .DB_CYCLES(1)) u_p5 (
        .clk(clk), .rst_n(rst_n), .en(en5), .clear(clear5),
        .go(go5), .go_back(go_back5), .state(state5)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, sample 1 time unit later and
    // check the output invariants on both instances.
    task automatic step(input bit e, input bit [2:0] c);
        en = e;
        clear = c;
        @(posedge clk);
        #1;
        chk("onehot0_go", 32'($onehot0(go)), 1);
        chk("back_excl_go", 32'(go_back && (go != 0)), 0);
        chk("onehot0_go5", 32'($onehot0(go5)), 1);
        chk("back_excl_go5", 32'(go_back5 && (go5 != 0)), 0);
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        en = 1'b0;
        clear = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Reference model: behaviour from the block's rules, in plain integers.
    int       m_mode, m_k, m_tmr, m_stop;
    bit [2:0] m_filt;
    int       m_run [3];

    function automatic void m_reset();
        m_mode = M_STOP; m_k = 0; m_tmr = 0; m_stop = 0; m_filt = '0;
        for (int i = 0; i < 3; i++) m_run[i] = 0;
    endfunction

    function automatic void m_enter(input int md);
        m_mode = md;
        m_tmr  = 0;
        m_stop = 0;
    endfunction

    function automatic void m_step(input bit e, input bit [2:0] c);
        int sk;
        sk = 0;
        if (m_filt[2]) sk = 2;
        if (m_filt[1]) sk = 1;
        case (m_mode)
            M_STOP: begin
                if (!e) m_stop = 0;
                else if (m_filt[0]) m_enter(M_FWD);
                else if (sk != 0) begin m_k = sk; m_enter(M_TURN); end
                else begin
                    m_stop++;
                    if (m_stop == STUCK) m_enter(M_BACK);
                end
            end
            M_FWD: begin
                if (!e) m_enter(M_STOP);
                else if (!m_filt[0]) begin
                    if (sk != 0) begin m_k = sk; m_enter(M_TURN); end
                    else m_enter(M_STOP);
                end
            end
            M_TURN: begin
                if (!e || !m_filt[m_k]) m_enter(M_STOP);
                else begin
                    m_tmr++;
                    if (m_tmr == TURN) m_enter(M_STOP);
                end
            end
            default: begin
                if (!e) m_enter(M_STOP);
                else begin
                    m_tmr++;
                    if (m_tmr == BACK) m_enter(M_STOP);
                end
            end
        endcase
        for (int i = 0; i < 3; i++) begin
            if (c[i] != m_filt[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_filt[i] = c[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
    endfunction

    function automatic logic [2:0] m_go();
        if (m_mode == M_FWD)  return 3'b001;
        if (m_mode == M_TURN) return 3'(1 << m_k);
        return 3'b000;
    endfunction

    typedef struct {
        bit       en;
        bit [2:0] clear;
        int       n;
        bit [2:0] go;
        bit       back;
        bit [1:0] st;
    } vec_t;

    vec_t tbl [26];

    initial begin
        // Sequence from reset: hold {en, clear} for n edges, then expect outputs.
        tbl[0]  = '{1, 3'b001,  4, 3'b000, 0, 2'b00}; // filt[0] rises on edge 4
        tbl[1]  = '{1, 3'b001,  1, 3'b001, 0, 2'b01}; // FWD on edge 5
        tbl[2]  = '{1, 3'b011,  3, 3'b001, 0, 2'b01}; // 3-cycle glitch on [1]
        tbl[3]  = '{1, 3'b001,  2, 3'b001, 0, 2'b01}; // glitch ignored
        tbl[4]  = '{1, 3'b000,  4, 3'b001, 0, 2'b01}; // filt[0] falls on edge 4
        tbl[5]  = '{1, 3'b000,  1, 3'b000, 0, 2'b00}; // FWD -> STOP, no side
        tbl[6]  = '{1, 3'b000, 31, 3'b000, 0, 2'b00}; // stuck count 31
        tbl[7]  = '{1, 3'b000,  1, 3'b000, 1, 2'b11}; // 32nd edge -> BACK
        tbl[8]  = '{1, 3'b000, 15, 3'b000, 1, 2'b11}; // reverse still running
        tbl[9]  = '{1, 3'b000,  1, 3'b000, 0, 2'b00}; // 16 cycles of reverse done
        tbl[10] = '{1, 3'b110,  4, 3'b000, 0, 2'b00};
        tbl[11] = '{1, 3'b110,  1, 3'b010, 0, 2'b10}; // TURN k=1
        tbl[12] = '{1, 3'b110,  7, 3'b010, 0, 2'b10};
        tbl[13] = '{1, 3'b110,  1, 3'b000, 0, 2'b00}; // 8th edge -> STOP
        tbl[14] = '{1, 3'b110,  1, 3'b010, 0, 2'b10}; // re-evaluated, turn again
        tbl[15] = '{1, 3'b100,  4, 3'b010, 0, 2'b10}; // filt[1] drops on edge 4
        tbl[16] = '{1, 3'b100,  1, 3'b000, 0, 2'b00}; // abort on edge 5
        tbl[17] = '{1, 3'b100,  1, 3'b100, 0, 2'b10}; // filt[2] sole side
        tbl[18] = '{1, 3'b001,  4, 3'b100, 0, 2'b10};
        tbl[19] = '{1, 3'b001,  1, 3'b000, 0, 2'b00};
        tbl[20] = '{1, 3'b001,  1, 3'b001, 0, 2'b01};
        tbl[21] = '{1, 3'b100,  4, 3'b001, 0, 2'b01};
        tbl[22] = '{1, 3'b100,  1, 3'b100, 0, 2'b10}; // FWD -> TURN go=100
        tbl[23] = '{0, 3'b100,  1, 3'b000, 0, 2'b00}; // en=0 -> STOP next edge
        tbl[24] = '{0, 3'b100,  3, 3'b000, 0, 2'b00};
        tbl[25] = '{1, 3'b100,  1, 3'b100, 0, 2'b10};

        rst_pulse();
        chk("reset_go", go, 0);
        chk("reset_back", go_back, 0);
        chk("reset_state", state, 0);

        for (int r = 0; r < 26; r++) begin
            repeat (tbl[r].n) step(tbl[r].en, tbl[r].clear);
            chk($sformatf("tbl%0d_go", r), go, tbl[r].go);
            chk($sformatf("tbl%0d_back", r), go_back, tbl[r].back);
            chk($sformatf("tbl%0d_state", r), state, tbl[r].st);
        end

        // Stuck recovery restarts its count, then en=0 aborts the reverse.
        rst_pulse();
        repeat (32) step(1, 3'b000);
        chk("stuck_back", go_back, 1);
        repeat (16) step(1, 3'b000);
        chk("stuck_done", state, 0);
        repeat (31) step(1, 3'b000);
        chk("stuck_restart_wait", state, 0);
        step(1, 3'b000);
        chk("stuck_restart_back", state, 3);
        step(0, 3'b000);
        chk("en0_back_state", state, 0);
        chk("en0_back_out", go_back, 0);

        // Asynchronous reset mid-turn; debounce must start over afterwards.
        rst_pulse();
        repeat (5) step(1, 3'b110);
        chk("pre_rst_turn", go, 3'b010);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_go", go, 0);
        chk("async_rst_state", state, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) step(1, 3'b110);
        chk("post_rst_filt_wait", state, 0);
        step(1, 3'b110);
        chk("post_rst_turn", go, 3'b010);

        // Five-direction instance with single-cycle debounce.
        rst_pulse();
        en5 = 1'b1;
        clear5 = 5'b10110;
        step(0, 3'b000);
        chk("p5_edge1_state", state5, 0);
        step(0, 3'b000);
        chk("p5_go", go5, 5'b00010);
        chk("p5_state", state5, 2);
        en5 = 1'b0;
        clear5 = '0;

        // Randomised run against the reference model.
        rst_pulse();
        m_reset();
        for (int seg = 0; seg < 300; seg++) begin
            bit       e;
            bit [2:0] c;
            int       h;
            e = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 3) == 0) c = 3'b000;
            else c = 3'($urandom);
            if (c == 3'b000) h = $urandom_range(1, 45);
            else h = $urandom_range(1, 12);
            for (int j = 0; j < h; j++) begin
                step(e, c);
                m_step(e, c);
                chk("rnd_go", go, m_go());
                chk("rnd_back", go_back, (m_mode == M_BACK) ? 1 : 0);
                chk("rnd_state", state, m_mode);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
